// File: rtl/bomb_tick_engine_if.sv
// Bundle between the bomb-placement controller and the tick engine: maps in, committed maps out,
// player positions, and the tick/busy/done handshake.
interface bomb_tick_engine_if #(
  parameter int unsigned N = 10
);
  localparam int unsigned NCells = N * N;

  logic              tick;
  logic [NCells-1:0] arena_in;
  logic [NCells-1:0] bomb_bit0_in;
  logic [NCells-1:0] bomb_bit1_in;
  logic [3:0]        pa_x;
  logic [3:0]        pa_y;
  logic [3:0]        pb_x;
  logic [3:0]        pb_y;
  logic [NCells-1:0] arena_out;
  logic [NCells-1:0] bomb_bit0_out;
  logic [NCells-1:0] bomb_bit1_out;
  logic [NCells-1:0] flame;
  logic              hit_a;
  logic              hit_b;
  logic              busy;
  logic              done;

  modport master (
    output tick, arena_in, bomb_bit0_in, bomb_bit1_in, pa_x, pa_y, pb_x, pb_y,
    input  arena_out, bomb_bit0_out, bomb_bit1_out, flame, hit_a, hit_b, busy, done
  );

  modport slave (
    input  tick, arena_in, bomb_bit0_in, bomb_bit1_in, pa_x, pa_y, pb_x, pb_y,
    output arena_out, bomb_bit0_out, bomb_bit1_out, flame, hit_a, hit_b, busy, done
  );
endinterface

// File: rtl/bomb_tick_engine.sv
// Per-tick bomb countdown and cross-shaped blast propagation over the arena; all results are
// built in a working copy and committed to the outputs in a single cycle.
module bomb_tick_engine #(
  parameter int unsigned RADIUS = 2,
  parameter int unsigned N      = 10
) (
  input logic               clk,
  input logic               rst_n,
  bomb_tick_engine_if.slave eng_io
);
  localparam int unsigned NCells = N * N;
  localparam int unsigned IdxW   = $clog2(NCells);
  // One spare bit so that both overshoot and underflow land at or above N.
  localparam int unsigned CoordW = $clog2(N + RADIUS) + 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NCells - 1);
  localparam logic [CoordW-1:0] NCoord   = CoordW'(N);
  localparam logic [CoordW-1:0] RadCoord = CoordW'(RADIUS);
  localparam logic [CoordW-1:0] OneCoord = CoordW'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StScan, StBlast, StCommit} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CoordW-1:0] cx_q, cx_d, cy_q, cy_d, k_q, k_d;
  logic [NCells-1:0] arena_q, arena_d, b0_q, b0_d, b1_q, b1_d, flame_q, flame_d;
  logic [NCells-1:0] arena_out_q, b0_out_q, b1_out_q, flame_out_q;
  logic              hit_a_q, hit_b_q;

  logic [CoordW-1:0] tx, ty;
  logic              off_grid;
  logic [IdxW-1:0]   tidx, pa_idx, pb_idx;
  logic [1:0]        cur_code, tgt_code;
  logic              pa_hit, pb_hit;
  logic              adv, end_dir;

  always_comb begin
    tx = cx_q;
    ty = cy_q;
    unique case (dir_q)
      DirUp:    tx = cx_q - k_q;
      DirDown:  tx = cx_q + k_q;
      DirLeft:  ty = cy_q - k_q;
      DirRight: ty = cy_q + k_q;
    endcase
    off_grid = (tx >= NCoord) || (ty >= NCoord);
    tidx     = IdxW'(32'(tx) * N + 32'(ty));
    cur_code = {b1_q[idx_q], b0_q[idx_q]};
    tgt_code = {b1_q[tidx], b0_q[tidx]};
    pa_idx   = IdxW'(32'(eng_io.pa_x) * N + 32'(eng_io.pa_y));
    pb_idx   = IdxW'(32'(eng_io.pb_x) * N + 32'(eng_io.pb_y));
    pa_hit   = (32'(eng_io.pa_x) < N) && (32'(eng_io.pa_y) < N) && flame_q[pa_idx];
    pb_hit   = (32'(eng_io.pb_x) < N) && (32'(eng_io.pb_y) < N) && flame_q[pb_idx];
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    k_d     = k_q;
    arena_d = arena_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    flame_d = flame_q;
    adv     = 1'b0;
    end_dir = 1'b0;
    unique case (state_q)
      StIdle: if (eng_io.tick) state_d = StLoad;
      StLoad: begin
        arena_d = eng_io.arena_in;
        b0_d    = eng_io.bomb_bit0_in;
        b1_d    = eng_io.bomb_bit1_in;
        flame_d = '0;
        idx_d   = '0;
        cx_d    = '0;
        cy_d    = '0;
        state_d = StScan;
      end
      StScan: begin
        unique case (cur_code)
          2'd3: begin
            b0_d[idx_q] = 1'b0;
            adv         = 1'b1;
          end
          2'd2: begin
            b1_d[idx_q] = 1'b0;
            b0_d[idx_q] = 1'b1;
            adv         = 1'b1;
          end
          2'd1: begin
            b0_d[idx_q]    = 1'b0;
            flame_d[idx_q] = 1'b1;
            dir_d          = DirUp;
            k_d            = OneCoord;
            state_d        = StBlast;
          end
          default: adv = 1'b1;
        endcase
      end
      StBlast: begin
        if (off_grid) begin
          end_dir = 1'b1;
        end else if (arena_q[tidx]) begin
          arena_d[tidx] = 1'b0;
          flame_d[tidx] = 1'b1;
          end_dir       = 1'b1;
        end else if (tgt_code != 2'd0) begin
          // Chained bomb is armed to 1; the scan order decides whether it fires this pass.
          b1_d[tidx]    = 1'b0;
          b0_d[tidx]    = 1'b1;
          flame_d[tidx] = 1'b1;
          end_dir       = 1'b1;
        end else begin
          flame_d[tidx] = 1'b1;
          if (k_q == RadCoord) end_dir = 1'b1;
          else k_d = k_q + OneCoord;
        end
        if (end_dir) begin
          k_d = OneCoord;
          if (dir_q == DirRight) adv = 1'b1;
          else dir_d = dir_e'(dir_q + 2'd1);
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (adv) begin
      if (idx_q == LastIdx) begin
        state_d = StCommit;
      end else begin
        state_d = StScan;
        idx_d   = idx_q + IdxW'(1);
        if (cy_q == NCoord - OneCoord) begin
          cy_d = '0;
          cx_d = cx_q + OneCoord;
        end else begin
          cy_d = cy_q + OneCoord;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= DirUp;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      k_q     <= '0;
      arena_q <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      flame_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      k_q     <= k_d;
      arena_q <= arena_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      flame_q <= flame_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arena_out_q <= '0;
      b0_out_q    <= '0;
      b1_out_q    <= '0;
      flame_out_q <= '0;
      hit_a_q     <= 1'b0;
      hit_b_q     <= 1'b0;
    end else if (state_q == StCommit) begin
      arena_out_q <= arena_q;
      b0_out_q    <= b0_q;
      b1_out_q    <= b1_q;
      flame_out_q <= flame_q;
      hit_a_q     <= hit_a_q | pa_hit;
      hit_b_q     <= hit_b_q | pb_hit;
    end
  end

  always_comb begin
    eng_io.arena_out     = arena_out_q;
    eng_io.bomb_bit0_out = b0_out_q;
    eng_io.bomb_bit1_out = b1_out_q;
    eng_io.flame         = flame_out_q;
    eng_io.hit_a         = hit_a_q;
    eng_io.hit_b         = hit_b_q;
    eng_io.busy          = (state_q != StIdle);
    eng_io.done          = (state_q == StCommit);
  end
endmodule

// File: tb/tb_bomb_tick_engine.sv
// Scoreboard bench: each tick pushes a hand-derived expected commit, popped when done fires.
module tb_bomb_tick_engine;
  localparam int unsigned N  = 10;
  localparam int unsigned NC = N * N;

  typedef logic [NC-1:0] map_t;
  typedef struct {
    string tag;
    map_t  arena;
    map_t  b0;
    map_t  b1;
    map_t  flame;
    logic  hit_a;
    logic  hit_b;
    int    lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  bomb_tick_engine_if #(.N(N)) eng_if ();

  bomb_tick_engine #(.RADIUS(2), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .eng_io(eng_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (eng_if.done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input map_t got, input map_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic map_t bt(input int i);
    map_t m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic exp_t mk(input string tag, input map_t a, input map_t b0, input map_t b1,
                              input map_t f, input logic ha, input logic hb, input int lat);
    exp_t e;
    e.tag = tag; e.arena = a; e.b0 = b0; e.b1 = b1; e.flame = f;
    e.hit_a = ha; e.hit_b = hb; e.lat = lat;
    return e;
  endfunction

  // lat of 0 means the exact commit cycle is not compared, only that done arrives.
  task automatic run_tick(input map_t a, input map_t b0, input map_t b1, input logic [3:0] ax,
                          input logic [3:0] ay, input logic [3:0] bx, input logic [3:0] by,
                          input exp_t e);
    exp_t g;
    int   n;
    eng_if.arena_in     = a;
    eng_if.bomb_bit0_in = b0;
    eng_if.bomb_bit1_in = b1;
    eng_if.pa_x = ax; eng_if.pa_y = ay; eng_if.pb_x = bx; eng_if.pb_y = by;
    sb.push_back(e);
    @(negedge clk); eng_if.tick = 1'b1;
    @(negedge clk); eng_if.tick = 1'b0;
    n = 1;
    while (eng_if.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    g = sb.pop_front();
    check_val({g.tag, ".done_seen"}, map_t'(eng_if.done), map_t'(1'b1));
    if (g.lat != 0) check_val({g.tag, ".latency"}, map_t'(n), map_t'(g.lat));
    @(posedge clk); #1;
    check_val({g.tag, ".arena"}, eng_if.arena_out, g.arena);
    check_val({g.tag, ".bomb0"}, eng_if.bomb_bit0_out, g.b0);
    check_val({g.tag, ".bomb1"}, eng_if.bomb_bit1_out, g.b1);
    check_val({g.tag, ".flame"}, eng_if.flame, g.flame);
    check_val({g.tag, ".hit_a"}, map_t'(eng_if.hit_a), map_t'(g.hit_a));
    check_val({g.tag, ".hit_b"}, map_t'(eng_if.hit_b), map_t'(g.hit_b));
    check_val({g.tag, ".idle"}, map_t'({eng_if.busy, eng_if.done}), map_t'(2'b00));
  endtask

  initial begin
    map_t f2, f3, f4, f5a, f5b, z;
    int   base, first_done, n;
    z   = '0;
    f2  = bt(44) | bt(34) | bt(24) | bt(54) | bt(64) | bt(43) | bt(42) | bt(45) | bt(46);
    f3  = bt(44) | bt(34) | bt(54) | bt(64) | bt(43) | bt(42) | bt(45) | bt(46);
    f4  = bt(0) | bt(10) | bt(20) | bt(1) | bt(2);
    f5a = f2 | bt(36) | bt(26) | bt(56) | bt(66) | bt(47) | bt(48);
    f5b = bt(42) | bt(32) | bt(22) | bt(52) | bt(62) | bt(41) | bt(40) | bt(43) | bt(44);

    rst_n = 1'b0;
    eng_if.tick = 1'b0;
    eng_if.arena_in = z; eng_if.bomb_bit0_in = z; eng_if.bomb_bit1_in = z;
    eng_if.pa_x = 4'd15; eng_if.pa_y = 4'd15; eng_if.pb_x = 4'd15; eng_if.pb_y = 4'd15;
    repeat (3) @(negedge clk);
    check_val("rst.arena", eng_if.arena_out, z);
    check_val("rst.flame", eng_if.flame, z);
    check_val("rst.flags", map_t'({eng_if.hit_a, eng_if.hit_b, eng_if.busy, eng_if.done}),
              map_t'(4'b0000));
    rst_n = 1'b1;
    @(negedge clk);

    run_tick(z, z, z, 4'd15, 4'd15, 4'd15, 4'd15, mk("t1", z, z, z, z, 1'b0, 1'b0, 102));

    run_tick(bt(14), bt(44), bt(44), 4'd15, 4'd15, 4'd15, 4'd15,
             mk("t2a", bt(14), z, bt(44), z, 1'b0, 1'b0, 102));
    run_tick(bt(14), z, bt(44), 4'd15, 4'd15, 4'd15, 4'd15,
             mk("t2b", bt(14), bt(44), z, z, 1'b0, 1'b0, 102));
    run_tick(bt(14), bt(44), z, 4'd15, 4'd15, 4'd15, 4'd15,
             mk("t2c", bt(14), z, z, f2, 1'b0, 1'b0, 0));

    run_tick(bt(34) | bt(46), bt(44), z, 4'd15, 4'd15, 4'd15, 4'd15,
             mk("t3", z, z, z, f3, 1'b0, 1'b0, 0));

    // Player B at (1,10): the flat index would alias burned cell 20, yet it is off-grid.
    run_tick(z, bt(0), z, 4'd2, 4'd0, 4'd1, 4'd10, mk("t4a", z, z, z, f4, 1'b1, 1'b0, 0));
    run_tick(z, z, z, 4'd0, 4'd0, 4'd15, 4'd15, mk("t4b", z, z, z, z, 1'b1, 1'b0, 102));

    run_tick(bt(99), bt(44) | bt(46) | bt(42), bt(46) | bt(42), 4'd15, 4'd15, 4'd6, 4'd6,
             mk("t5a", bt(99), bt(42), z, f5a, 1'b1, 1'b1, 0));
    run_tick(bt(99), bt(42), z, 4'd15, 4'd15, 4'd15, 4'd15,
             mk("t5b", bt(99), z, z, f5b, 1'b1, 1'b1, 0));

    eng_if.arena_in = bt(7); eng_if.bomb_bit0_in = bt(44); eng_if.bomb_bit1_in = z;
    @(negedge clk); eng_if.tick = 1'b1;
    @(negedge clk); eng_if.tick = 1'b0;
    repeat (30) @(negedge clk);
    check_val("t6.busy_mid", map_t'(eng_if.busy), map_t'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check_val("t6.rst_arena", eng_if.arena_out, z);
    check_val("t6.rst_flame", eng_if.flame, z);
    check_val("t6.rst_flags", map_t'({eng_if.hit_a, eng_if.hit_b, eng_if.busy, eng_if.done}),
              map_t'(4'b0000));
    @(negedge clk); rst_n = 1'b1;
    base = done_cnt;
    repeat (150) @(negedge clk);
    check_val("t6.no_commit", map_t'(done_cnt - base), z);
    check_val("t6.arena_held", eng_if.arena_out, z);

    eng_if.arena_in = z; eng_if.bomb_bit0_in = z; eng_if.bomb_bit1_in = z;
    base = done_cnt;
    first_done = 0;
    @(negedge clk); eng_if.tick = 1'b1;
    @(negedge clk); eng_if.tick = 1'b0;
    n = 1;
    while (n < 400) begin
      eng_if.tick = (n == 50);
      if (eng_if.done === 1'b1 && first_done == 0) first_done = n;
      @(negedge clk);
      n++;
    end
    eng_if.tick = 1'b0;
    check_val("t6.one_done", map_t'(done_cnt - base), map_t'(1));
    check_val("t6.done_cycle", map_t'(first_done), map_t'(102));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
